store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the pipelined core's memory-stage outputs (MemWrite, DataAdr, WriteData) and data memory. Stores retire from the core in one cycle and drain to memory in program order whenever memory is ready. Loads that hit a pending store get the youngest matching data forwarded. This decouples core progress from memory write latency.

## Interface
- DEPTH, 4, number of entries; must be a power of two, 2 or more.
- AW, 32, address width.
- DW, 32, data width.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- MemWrite  in  1  core store request this cycle.
- DataAdr  in  AW  core byte address, used by both stores and load lookups.
- WriteData  in  DW  core store data.
- Stall  out  1  store refused this cycle; core must hold the request.
- FwdHit  out  1  DataAdr word matches a pending entry.
- FwdData  out  DW  data of the youngest matching entry; 0 when FwdHit=0.
- mem_we  out  1  head entry valid and offered to memory.
- mem_adr  out  AW  head entry address.
- mem_wd  out  DW  head entry data.
- mem_ready  in  1  memory accepts the offered write this cycle.
- count  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Circular FIFO: head pointer, tail pointer and count registers. Both pointers wrap modulo DEPTH.
- full = (count == DEPTH); empty = (count == 0).
- Enqueue when MemWrite & ~full: the entry at the tail captures {DataAdr, WriteData} and the tail advances.
- Stall = MemWrite & full (combinational).
  - Stall is asserted even if a dequeue happens in the same cycle. No bypass into a full buffer.
- Dequeue when mem_we & mem_ready: the head advances.
- mem_we = ~empty. mem_adr and mem_wd come straight from the head entry's registers.
- Simultaneous enqueue and dequeue (not full, not empty): count is unchanged and both pointers advance.
- Forwarding is combinational:
  - Compare DataAdr[AW-1:2] against every valid entry.
  - The youngest match (closest to the tail) wins.
  - Evaluated regardless of MemWrite; the core ignores it on stores.
- An entry being dequeued this cycle is still valid for forwarding in this cycle.
- A store being enqueued this cycle is not visible to forwarding until the next cycle.
- No write merging. Duplicate addresses occupy separate entries and drain in order.

## Timing
- Reset (synchronous): head=0, tail=0, count=0, all entries invalid.
  - Outputs during and after reset: mem_we=0, Stall=0, FwdHit=0, FwdData=0.
  - mem_adr and mem_wd are don't-care while mem_we=0.
- Reset asserted mid-operation discards all pending stores. mem_we is 0 in the cycle after the reset edge.
- Store latency: a store accepted at edge N into an empty buffer gives mem_we=1 with its address and data during cycle N+1.
  - Earliest retirement is edge N+1 if mem_ready=1.
- Throughput: one enqueue and one dequeue per cycle sustained.
- Ordering: memory sees writes in exactly the order they were accepted, including across pointer wrap.
- mem_ready is sampled only while mem_we=1. Its value when the buffer is empty has no effect.

## Test plan
- Reset, then MemWrite=1, DataAdr=100, WriteData=7 for one cycle with mem_ready=1.
  - Next cycle: mem_we=1, mem_adr=100, mem_wd=7, count=1.
  - The cycle after: mem_we=0, count=0.
- Fill with mem_ready=0: stores to 96, 100, 104, 108 (data 1..4).
  - Result: count=4.
  - A fifth store gives Stall=1, and count stays 4 across the edge.
  - Raise mem_ready: drains 96, 100, 104, 108 on four consecutive cycles. Stall drops once count<4.
- Forwarding with mem_ready=0: store 100←7, then 100←9.
  - DataAdr=100, MemWrite=0 gives FwdHit=1, FwdData=9.
  - DataAdr=102 gives FwdHit=1, FwdData=9 (same word).
  - DataAdr=96 gives FwdHit=0, FwdData=0.
- Wrap and concurrency: 10 stores with data 0..9 and mem_ready toggling every cycle.
  - Memory receives 0..9 in order.
  - count never exceeds DEPTH, and is unchanged on cycles that both enqueue and dequeue.
- Reset mid-operation: 3 entries pending, assert reset for one cycle.
  - Next cycle: count=0, mem_we=0, FwdHit=0.
  - A new store to 100←7 then drains normally.

Source files
------------

// File: rtl/store_buffer_if.sv
// Core/memory-side signal bundle for store_buffer.
// slave = the buffer itself; master = whatever drives the core and memory sides.
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          MemWrite;
  logic [AW-1:0] DataAdr;
  logic [DW-1:0] WriteData;
  logic          Stall;
  logic          FwdHit;
  logic [DW-1:0] FwdData;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic          mem_ready;
  logic [CW-1:0] count;

  modport slave (
    input  MemWrite, DataAdr, WriteData, mem_ready,
    output Stall, FwdHit, FwdData, mem_we, mem_adr, mem_wd, count
  );

  modport master (
    output MemWrite, DataAdr, WriteData, mem_ready,
    input  Stall, FwdHit, FwdData, mem_we, mem_adr, mem_wd, count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer: in-order circular FIFO of stores draining to data memory,
// with combinational youngest-match forwarding to loads.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] adr_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] count_q;
  logic          full, empty, enq, deq;
  logic          hit;
  logic [DW-1:0] fwd_data;
  logic          unused_adr_bits;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign enq   = bus.MemWrite & ~full;
  assign deq   = ~empty & bus.mem_ready;

  assign bus.Stall   = bus.MemWrite & full;
  assign bus.mem_we  = ~empty;
  assign bus.mem_adr = adr_q[head];
  assign bus.mem_wd  = data_q[head];
  assign bus.count   = count_q;
  assign bus.FwdHit  = hit;
  assign bus.FwdData = fwd_data;

  // Forwarding works on word addresses; the byte offset is irrelevant.
  assign unused_adr_bits = ^bus.DataAdr[1:0];

  always_ff @(posedge clk) begin
    if (enq) begin
      adr_q[tail]  <= bus.DataAdr;
      data_q[tail] <= bus.WriteData;
    end
  end

  // Entry validity is implied by count relative to head, so reset only clears pointers/count.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Walk from oldest to youngest so later matches override earlier ones.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count_q) && (adr_q[idx][AW-1:2] == bus.DataAdr[AW-1:2])) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, AW=DW=32).
module tb_store_buffer;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  store_buffer_if #(.DEPTH(4), .AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int sent, recv, mcount, cyc_n;
    logic en, de;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = '0;
    bus.WriteData = '0;
    bus.mem_ready = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_count", bus.count, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_stall", bus.Stall, 0);
    chk("rst_fwdhit", bus.FwdHit, 0);
    chk("rst_fwddata", bus.FwdData, 0);
    reset = 1'b0;
    cyc();

    // Single store, immediate drain
    bus.MemWrite = 1'b1; bus.DataAdr = 100; bus.WriteData = 7; bus.mem_ready = 1'b1;
    settle();
    chk("t1_stall", bus.Stall, 0);
    chk("t1_fwd_not_yet", bus.FwdHit, 0);
    cyc();
    bus.MemWrite = 1'b0;
    settle();
    chk("t1_mem_we", bus.mem_we, 1);
    chk("t1_mem_adr", bus.mem_adr, 100);
    chk("t1_mem_wd", bus.mem_wd, 7);
    chk("t1_count", bus.count, 1);
    chk("t1_fwd_dequeuing", bus.FwdHit, 1);
    chk("t1_fwd_dequeuing_data", bus.FwdData, 7);
    cyc();
    chk("t1_mem_we_after", bus.mem_we, 0);
    chk("t1_count_after", bus.count, 0);

    // Fill to full with memory not ready
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.MemWrite = 1'b1; bus.DataAdr = 96 + 4 * i; bus.WriteData = i + 1;
      cyc();
    end
    chk("t2_count_full", bus.count, 4);
    bus.DataAdr = 112; bus.WriteData = 5;
    settle();
    chk("t2_stall_full", bus.Stall, 1);
    cyc();
    chk("t2_count_held", bus.count, 4);
    chk("t2_stall_held", bus.Stall, 1);
    bus.mem_ready = 1'b1;
    settle();
    chk("t2_stall_with_deq", bus.Stall, 1);
    chk("t2_drain0_adr", bus.mem_adr, 96);
    chk("t2_drain0_wd", bus.mem_wd, 1);
    cyc();
    chk("t2_count_3", bus.count, 3);
    chk("t2_stall_drop", bus.Stall, 0);
    chk("t2_drain1_adr", bus.mem_adr, 100);
    chk("t2_drain1_wd", bus.mem_wd, 2);
    cyc();
    bus.MemWrite = 1'b0;
    settle();
    chk("t2_count_enq_deq", bus.count, 3);
    chk("t2_drain2_adr", bus.mem_adr, 104);
    chk("t2_drain2_wd", bus.mem_wd, 3);
    cyc();
    chk("t2_drain3_adr", bus.mem_adr, 108);
    chk("t2_drain3_wd", bus.mem_wd, 4);
    cyc();
    chk("t2_drain4_adr", bus.mem_adr, 112);
    chk("t2_drain4_wd", bus.mem_wd, 5);
    cyc();
    chk("t2_empty_we", bus.mem_we, 0);
    chk("t2_empty_count", bus.count, 0);

    // Forwarding: youngest match wins, word granularity
    bus.mem_ready = 1'b0;
    bus.MemWrite = 1'b1; bus.DataAdr = 100; bus.WriteData = 7; cyc();
    bus.DataAdr = 100; bus.WriteData = 9; cyc();
    bus.DataAdr = 104; bus.WriteData = 3; cyc();
    bus.MemWrite = 1'b0; bus.DataAdr = 100;
    settle();
    chk("t3_count", bus.count, 3);
    chk("t3_hit_100", bus.FwdHit, 1);
    chk("t3_data_100", bus.FwdData, 9);
    bus.DataAdr = 102; settle();
    chk("t3_hit_102", bus.FwdHit, 1);
    chk("t3_data_102", bus.FwdData, 9);
    bus.DataAdr = 107; settle();
    chk("t3_hit_107", bus.FwdHit, 1);
    chk("t3_data_107", bus.FwdData, 3);
    bus.DataAdr = 96; settle();
    chk("t3_hit_96", bus.FwdHit, 0);
    chk("t3_data_96", bus.FwdData, 0);
    bus.mem_ready = 1'b1;
    settle();
    chk("t3_order0", bus.mem_wd, 7); cyc();
    chk("t3_order1", bus.mem_wd, 9); cyc();
    chk("t3_order2", bus.mem_wd, 3); cyc();
    chk("t3_empty", bus.mem_we, 0);
    cyc();
    chk("t3_ready_when_empty", bus.count, 0);

    // Wrap and concurrency with mem_ready toggling each cycle
    sent = 0; recv = 0; mcount = 0; cyc_n = 0;
    while (recv < 10 && cyc_n < 60) begin
      bus.mem_ready = cyc_n[0];
      bus.MemWrite  = (sent < 10);
      bus.DataAdr   = 200 + 4 * sent;
      bus.WriteData = sent;
      settle();
      chk("t4_count", bus.count, mcount);
      chk("t4_stall", bus.Stall, (sent < 10) && (mcount == 4));
      en = (sent < 10) && (mcount != 4);
      de = (mcount != 0) && bus.mem_ready;
      if (de) begin
        chk("t4_order_wd", bus.mem_wd, recv);
        chk("t4_order_adr", bus.mem_adr, 200 + 4 * recv);
        recv++;
      end
      if (en) sent++;
      mcount = mcount + (en ? 1 : 0) - (de ? 1 : 0);
      cyc_n++;
      cyc();
    end
    chk("t4_all_received", recv, 10);
    bus.MemWrite = 1'b0;
    chk("t4_final_count", bus.count, 0);

    // Reset mid-operation discards pending stores
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.MemWrite = 1'b1; bus.DataAdr = 300 + 4 * i; bus.WriteData = 20 + i;
      cyc();
    end
    bus.MemWrite = 1'b0; bus.DataAdr = 300;
    settle();
    chk("t5_count_pre", bus.count, 3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    chk("t5_count_rst", bus.count, 0);
    chk("t5_we_rst", bus.mem_we, 0);
    chk("t5_fwd_rst", bus.FwdHit, 0);
    bus.MemWrite = 1'b1; bus.DataAdr = 100; bus.WriteData = 7;
    cyc();
    bus.MemWrite = 1'b0; bus.mem_ready = 1'b1;
    settle();
    chk("t5_new_we", bus.mem_we, 1);
    chk("t5_new_adr", bus.mem_adr, 100);
    chk("t5_new_wd", bus.mem_wd, 7);
    cyc();
    chk("t5_drained", bus.mem_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
